// File: rtl/rf_wb_arb.sv
// Register-file write arbiter: WB stage has priority, mul/div results queue in a FIFO.
// Optional same-cycle bypass port enabled by defining RF_WB_BYPASS_EN.
module rf_wb_arb #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          md_valid,
    output logic          md_ready,
    input  logic [AW-1:0] md_addr,
    input  logic [DW-1:0] md_data,
    input  logic          md_issue,
    input  logic [AW-1:0] md_issue_addr,
    output logic [31:0]   busy,
    output logic          md_pending,
`ifdef RF_WB_BYPASS_EN
    input  logic [AW-1:0] byp_addr,
    output logic          byp_hit,
    output logic [DW-1:0] byp_data,
`endif
    output logic          wren,
    output logic [AW-1:0] wraddr,
    output logic [DW-1:0] wrdata
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [AW+DW-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             wren_q, wren_d;
    logic [AW-1:0]    wraddr_q, wraddr_d;
    logic [DW-1:0]    wrdata_q, wrdata_d;
    logic [31:0]      busy_q, busy_d;

    logic          wb_act, empty, full;
    logic          push_nz, pop, bypass, enq;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic          clr;
    logic [AW-1:0] clr_addr;

    assign wb_act    = wb_en && (wb_addr != '0);
    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign md_ready  = !full;
    assign push_nz   = md_valid && !full && (md_addr != '0);
    assign pop       = !wb_act && !empty;
    assign bypass    = !wb_act && empty && push_nz;
    assign enq       = push_nz && !bypass;
    assign head_addr = mem_q[rd_ptr_q][AW+DW-1:DW];
    assign head_data = mem_q[rd_ptr_q][DW-1:0];

    always_comb begin
        wren_d   = 1'b0;
        wraddr_d = wraddr_q;
        wrdata_d = wrdata_q;
        clr      = 1'b0;
        clr_addr = '0;
        if (wb_act) begin
            wren_d   = 1'b1;
            wraddr_d = wb_addr;
            wrdata_d = wb_data;
        end else if (pop) begin
            wren_d   = 1'b1;
            wraddr_d = head_addr;
            wrdata_d = head_data;
            clr      = 1'b1;
            clr_addr = head_addr;
        end else if (bypass) begin
            wren_d   = 1'b1;
            wraddr_d = md_addr;
            wrdata_d = md_data;
            clr      = 1'b1;
            clr_addr = md_addr;
        end
    end

    always_comb begin
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q;
        if (enq && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !enq) begin
            count_d = count_q - 1'b1;
        end
    end

    // Issue set is applied after the clear so a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        if (clr) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (md_issue && (md_issue_addr != '0)) begin
            busy_d[md_issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= {md_addr, md_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            wren_q   <= 1'b0;
            wraddr_q <= '0;
            wrdata_q <= '0;
            busy_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            wren_q   <= wren_d;
            wraddr_q <= wraddr_d;
            wrdata_q <= wrdata_d;
            busy_q   <= busy_d;
        end
    end

    assign wren       = wren_q;
    assign wraddr     = wraddr_q;
    assign wrdata     = wrdata_q;
    assign busy       = busy_q;
    assign md_pending = !empty;

`ifdef RF_WB_BYPASS_EN
    assign byp_hit  = wren_q && (wraddr_q == byp_addr) && (byp_addr != '0);
    assign byp_data = wrdata_q;
`endif

endmodule

// File: tb/tb_rf_wb_arb.sv
// Self-checking bench for rf_wb_arb against a queue-based reference model.
// Bypass checks are compiled in when RF_WB_BYPASS_EN is defined.
module tb_rf_wb_arb;

    localparam int DEPTH = 2;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          md_valid;
    logic          md_ready;
    logic [AW-1:0] md_addr;
    logic [DW-1:0] md_data;
    logic          md_issue;
    logic [AW-1:0] md_issue_addr;
    logic [31:0]   busy;
    logic          md_pending;
    logic          wren;
    logic [AW-1:0] wraddr;
    logic [DW-1:0] wrdata;
`ifdef RF_WB_BYPASS_EN
    logic [AW-1:0] byp_addr;
    logic          byp_hit;
    logic [DW-1:0] byp_data;
`endif

    rf_wb_arb #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .md_valid(md_valid), .md_ready(md_ready),
        .md_addr(md_addr), .md_data(md_data),
        .md_issue(md_issue), .md_issue_addr(md_issue_addr),
        .busy(busy), .md_pending(md_pending),
`ifdef RF_WB_BYPASS_EN
        .byp_addr(byp_addr), .byp_hit(byp_hit), .byp_data(byp_data),
`endif
        .wren(wren), .wraddr(wraddr), .wrdata(wrdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    logic          e_wren;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [31:0]   e_busy;
    int            errs = 0;
    int            checks = 0;

    task automatic model_reset();
        mq.delete();
        e_wren = 1'b0;
        e_addr = '0;
        e_data = '0;
        e_busy = '0;
    endtask

    // Reference: WB wins, else oldest queued result, else a fresh result.
    task automatic model_step();
        bit   acc;
        ent_t e;
        acc = md_valid && (mq.size() < DEPTH) && (md_addr != 0);
        if (wb_en && wb_addr != 0) begin
            e_wren = 1'b1;
            e_addr = wb_addr;
            e_data = wb_data;
            if (acc) mq.push_back('{md_addr, md_data});
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            e_wren = 1'b1;
            e_addr = e.a;
            e_data = e.d;
            e_busy[e.a] = 1'b0;
            if (acc) mq.push_back('{md_addr, md_data});
        end else if (acc) begin
            e_wren = 1'b1;
            e_addr = md_addr;
            e_data = md_data;
            e_busy[md_addr] = 1'b0;
        end else begin
            e_wren = 1'b0;
        end
        if (md_issue && md_issue_addr != 0) e_busy[md_issue_addr] = 1'b1;
        e_busy[0] = 1'b0;
    endtask

    task automatic idle_inputs();
        wb_en = 0; wb_addr = 0; wb_data = 0;
        md_valid = 0; md_addr = 0; md_data = 0;
        md_issue = 0; md_issue_addr = 0;
`ifdef RF_WB_BYPASS_EN
        byp_addr = 0;
`endif
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (wren !== 1'b0) begin errs++; $display("FAIL rst_wren got %0b exp 0", wren); end
        checks++; if (wraddr !== '0) begin errs++; $display("FAIL rst_wraddr got %0d exp 0", wraddr); end
        checks++; if (wrdata !== '0) begin errs++; $display("FAIL rst_wrdata got %h exp 0", wrdata); end
        checks++; if (busy !== '0) begin errs++; $display("FAIL rst_busy got %h exp 0", busy); end
        checks++; if (md_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got %0b exp 1", md_ready); end
        checks++; if (md_pending !== 1'b0) begin errs++; $display("FAIL rst_pending got %0b exp 0", md_pending); end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_wb_only();
        wb_en = 1; wb_addr = 5; wb_data = 32'h12345678;
        cycle();
        idle_inputs();
        checks++; if (wren !== 1'b1) begin errs++; $display("FAIL wb_wren got %0b exp 1", wren); end
        checks++; if (wraddr !== 5'd5) begin errs++; $display("FAIL wb_addr got %0d exp 5", wraddr); end
        checks++; if (wrdata !== 32'h12345678) begin errs++; $display("FAIL wb_data got %h exp 12345678", wrdata); end
`ifdef RF_WB_BYPASS_EN
        byp_addr = 5;
        #1;
        checks++; if (byp_hit !== 1'b1) begin errs++; $display("FAIL byp_hit got %0b exp 1", byp_hit); end
        checks++; if (byp_data !== 32'h12345678) begin errs++; $display("FAIL byp_data got %h exp 12345678", byp_data); end
        byp_addr = 0;
        #1;
        checks++; if (byp_hit !== 1'b0) begin errs++; $display("FAIL byp_hit0 got %0b exp 0", byp_hit); end
`endif
        cycle();
        checks++; if (wren !== 1'b0) begin errs++; $display("FAIL wb_idle got %0b exp 0", wren); end
        checks++; if (wraddr !== 5'd5) begin errs++; $display("FAIL wb_hold got %0d exp 5", wraddr); end
    endtask

    task automatic test_md_fallthrough();
        md_issue = 1; md_issue_addr = 9;
        cycle();
        idle_inputs();
        checks++; if (busy[9] !== 1'b1) begin errs++; $display("FAIL md_busy_set got %0b exp 1", busy[9]); end
        md_valid = 1; md_addr = 9; md_data = 32'hDEADBEEF;
        cycle();
        idle_inputs();
        checks++; if (wren !== 1'b1) begin errs++; $display("FAIL md_wren got %0b exp 1", wren); end
        checks++; if (wraddr !== 5'd9) begin errs++; $display("FAIL md_addr got %0d exp 9", wraddr); end
        checks++; if (wrdata !== 32'hDEADBEEF) begin errs++; $display("FAIL md_data got %h exp deadbeef", wrdata); end
        checks++; if (busy[9] !== 1'b0) begin errs++; $display("FAIL md_busy_clr got %0b exp 0", busy[9]); end
        checks++; if (md_pending !== 1'b0) begin errs++; $display("FAIL md_pend got %0b exp 0", md_pending); end
        cycle();
    endtask

    task automatic test_contention();
        md_issue = 1; md_issue_addr = 3;
        cycle();
        md_issue_addr = 4;
        cycle();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            wb_en = 1; wb_addr = 5'(10 + k); wb_data = 32'(100 + k);
            md_valid = (k < 2); md_addr = (k == 0) ? 5'd3 : 5'd4;
            md_data = (k == 0) ? 32'hAAAA0003 : 32'hBBBB0004;
            cycle();
            checks++; if (wraddr !== 5'(10 + k)) begin errs++; $display("FAIL ct_wb%0d got %0d exp %0d", k, wraddr, 10 + k); end
            if (k == 1) begin
                checks++; if (md_ready !== 1'b0) begin errs++; $display("FAIL ct_full got %0b exp 0", md_ready); end
            end
        end
        idle_inputs();
        cycle();
        checks++; if (wren !== 1'b1 || wraddr !== 5'd3 || wrdata !== 32'hAAAA0003) begin
            errs++; $display("FAIL ct_first got %0b/%0d/%h exp 1/3/aaaa0003", wren, wraddr, wrdata); end
        checks++; if (busy[3] !== 1'b0 || busy[4] !== 1'b1) begin
            errs++; $display("FAIL ct_busy1 got %0b%0b exp 01", busy[4], busy[3]); end
        cycle();
        checks++; if (wren !== 1'b1 || wraddr !== 5'd4 || wrdata !== 32'hBBBB0004) begin
            errs++; $display("FAIL ct_second got %0b/%0d/%h exp 1/4/bbbb0004", wren, wraddr, wrdata); end
        checks++; if (md_pending !== 1'b0 || md_ready !== 1'b1) begin
            errs++; $display("FAIL ct_drain got %0b/%0b exp 0/1", md_pending, md_ready); end
        cycle();
    endtask

    task automatic test_zero_addr();
        wb_en = 1; wb_addr = 11; wb_data = 32'h11;
        md_valid = 1; md_addr = 7; md_data = 32'hC0DE0007;
        cycle();
        idle_inputs();
        wb_en = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF;
        cycle();
        idle_inputs();
        checks++; if (wren !== 1'b1 || wraddr !== 5'd7 || wrdata !== 32'hC0DE0007) begin
            errs++; $display("FAIL z_wb0 got %0b/%0d/%h exp 1/7/c0de0007", wren, wraddr, wrdata); end
        md_valid = 1; md_addr = 0; md_data = 32'h5555;
        cycle();
        idle_inputs();
        checks++; if (wren !== 1'b0) begin errs++; $display("FAIL z_md0 got %0b exp 0", wren); end
        checks++; if (md_pending !== 1'b0) begin errs++; $display("FAIL z_pend got %0b exp 0", md_pending); end
        checks++; if (wraddr !== 5'd7) begin errs++; $display("FAIL z_hold got %0d exp 7", wraddr); end
    endtask

    task automatic test_set_clear();
        md_issue = 1; md_issue_addr = 6;
        cycle();
        idle_inputs();
        wb_en = 1; wb_addr = 12; wb_data = 32'h12;
        md_valid = 1; md_addr = 6; md_data = 32'h66;
        cycle();
        idle_inputs();
        md_issue = 1; md_issue_addr = 6;
        cycle();
        idle_inputs();
        checks++; if (wraddr !== 5'd6 || wren !== 1'b1) begin errs++; $display("FAIL sc_pop got %0b/%0d exp 1/6", wren, wraddr); end
        checks++; if (busy[6] !== 1'b1) begin errs++; $display("FAIL sc_busy got %0b exp 1", busy[6]); end
        md_valid = 1; md_addr = 6; md_data = 32'h67;
        cycle();
        idle_inputs();
        checks++; if (busy[6] !== 1'b0) begin errs++; $display("FAIL sc_clr got %0b exp 0", busy[6]); end
    endtask

    task automatic test_async_reset();
        md_issue = 1; md_issue_addr = 20;
        cycle();
        md_issue_addr = 21;
        wb_en = 1; wb_addr = 13; wb_data = 32'h13;
        md_valid = 1; md_addr = 20; md_data = 32'h20;
        cycle();
        md_issue = 0;
        md_addr = 21; md_data = 32'h21;
        cycle();
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        checks++; if (wren !== 1'b0) begin errs++; $display("FAIL ar_wren got %0b exp 0", wren); end
        checks++; if (busy !== '0) begin errs++; $display("FAIL ar_busy got %h exp 0", busy); end
        checks++; if (md_ready !== 1'b1) begin errs++; $display("FAIL ar_ready got %0b exp 1", md_ready); end
        checks++; if (md_pending !== 1'b0) begin errs++; $display("FAIL ar_pend got %0b exp 0", md_pending); end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        cycle();
        checks++; if (wren !== 1'b0) begin errs++; $display("FAIL ar_after got %0b exp 0", wren); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            wb_en = ($urandom_range(0, 99) < 45);
            wb_addr = 5'($urandom_range(0, 9));
            wb_data = $urandom;
            md_valid = ($urandom_range(0, 99) < 50);
            md_addr = 5'($urandom_range(0, 9));
            md_data = $urandom;
            md_issue = ($urandom_range(0, 99) < 30);
            md_issue_addr = 5'($urandom_range(0, 9));
            checks++; if (md_ready !== (mq.size() < DEPTH)) begin
                errs++; $display("FAIL rnd_ready i=%0d got %0b exp %0b", i, md_ready, mq.size() < DEPTH); end
            cycle();
            checks++; if (wren !== e_wren) begin errs++; $display("FAIL rnd_wren i=%0d got %0b exp %0b", i, wren, e_wren); end
            checks++; if (wraddr !== e_addr) begin errs++; $display("FAIL rnd_addr i=%0d got %0d exp %0d", i, wraddr, e_addr); end
            checks++; if (wrdata !== e_data) begin errs++; $display("FAIL rnd_data i=%0d got %h exp %h", i, wrdata, e_data); end
            checks++; if (busy !== e_busy) begin errs++; $display("FAIL rnd_busy i=%0d got %h exp %h", i, busy, e_busy); end
            checks++; if (md_pending !== (mq.size() != 0)) begin
                errs++; $display("FAIL rnd_pend i=%0d got %0b exp %0b", i, md_pending, mq.size() != 0); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_wb_only();
        test_md_fallthrough();
        test_contention();
        test_zero_addr();
        test_set_clear();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
